// File: rtl/seq_div_16.sv
// seq_div_16: 16-bit unsigned restoring divider, one quotient bit per clock.
// A start with a nonzero divisor runs 16 trial-subtraction iterations and
// pulses done 16 edges after acceptance. A zero divisor skips the iterations:
// done pulses one edge after acceptance, reporting quotient 16'hFFFF,
// remainder = dividend and div_by_zero = 1.
module seq_div_16 (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [15:0] a,
    input  logic [15:0] b,
    output logic [15:0] quotient,
    output logic [15:0] remainder,
    output logic        busy,
    output logic        done,
    output logic        div_by_zero
);

    localparam int unsigned W  = 16;
    localparam int unsigned CW = 4;
    localparam logic [CW-1:0] LAST_ITER = CW'(W - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t        state;
    logic [W-1:0]  dvd;      // dividend shift register, MSB consumed first
    logic [W-1:0]  dvs;      // captured divisor
    logic [W-1:0]  rem;      // running partial remainder
    logic [W-1:0]  quo;      // quotient bits shifted in from the LSB
    logic [CW-1:0] cnt;      // completed-iteration count
    logic          zpend;    // DONE was entered through the zero-divisor path

    logic [W:0]    partial_c;
    logic [W:0]    diff_c;
    logic          borrow_c;
    logic [W-1:0]  rem_nx_c;
    logic [W-1:0]  quo_nx_c;

    // One restoring step: the 17-bit compare covers divisors up to 16'hFFFF.
    // Because rem < dvs always holds, diff[16] is set exactly on a borrow.
    always_comb begin
        partial_c = {rem, dvd[W-1]};
        diff_c    = partial_c - {1'b0, dvs};
        borrow_c  = diff_c[W];
        rem_nx_c  = borrow_c ? partial_c[W-1:0] : diff_c[W-1:0];
        quo_nx_c  = {quo[W-2:0], ~borrow_c};
    end

    // Control FSM and datapath; results are published only at the done edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            dvd         <= '0;
            dvs         <= '0;
            rem         <= '0;
            quo         <= '0;
            cnt         <= '0;
            zpend       <= 1'b0;
            quotient    <= '0;
            remainder   <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
            div_by_zero <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        dvd <= a;
                        dvs <= b;
                        rem <= '0;
                        quo <= '0;
                        cnt <= '0;
                        if (b != '0) begin
                            div_by_zero <= 1'b0;
                            busy        <= 1'b1;
                            state       <= RUN;
                        end else begin
                            zpend <= 1'b1;
                            state <= DONE;
                        end
                    end
                end
                RUN: begin
                    dvd <= {dvd[W-2:0], 1'b0};
                    rem <= rem_nx_c;
                    quo <= quo_nx_c;
                    cnt <= cnt + CW'(1);
                    if (cnt == LAST_ITER) begin
                        quotient  <= quo_nx_c;
                        remainder <= rem_nx_c;
                        busy      <= 1'b0;
                        done      <= 1'b1;
                        state     <= DONE;
                    end
                end
                DONE: begin
                    // Zero-divisor results appear one edge after acceptance.
                    if (zpend) begin
                        zpend       <= 1'b0;
                        quotient    <= '1;
                        remainder   <= dvd;
                        div_by_zero <= 1'b1;
                        done        <= 1'b1;
                    end
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_seq_div_16.sv
// tb_seq_div_16: scoreboard bench for seq_div_16. Each accepted start pushes
// its expected result and completion cycle; the monitor pops on done.
module tb_seq_div_16;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [15:0] a;
    logic [15:0] b;
    logic [15:0] quotient;
    logic [15:0] remainder;
    logic        busy;
    logic        done;
    logic        div_by_zero;

    typedef struct {
        logic [15:0] q;
        logic [15:0] r;
        logic        dz;
        int          due;
    } exp_t;

    exp_t sb[$];
    int   cyc    = 0;
    int   passed = 0;
    int   total  = 0;

    seq_div_16 dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .a          (a),
        .b          (b),
        .quotient   (quotient),
        .remainder  (remainder),
        .busy       (busy),
        .done       (done),
        .div_by_zero(div_by_zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    endtask

    // Drive one start pulse sampled at the next posedge; push the expectation.
    task automatic start_div(input logic [15:0] aa, input logic [15:0] bb);
        exp_t e;
        @(negedge clk);
        a     = aa;
        b     = bb;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        if (bb == 16'd0) begin
            e.q   = 16'hFFFF;
            e.r   = aa;
            e.dz  = 1'b1;
            e.due = cyc + 1;
        end else begin
            e.q   = aa / bb;
            e.r   = aa % bb;
            e.dz  = 1'b0;
            e.due = cyc + 16;
        end
        sb.push_back(e);
        check("busy_after_accept", 32'(busy), 32'(bb != 16'd0));
    endtask

    // Wait (bounded) until every expected result has been observed.
    task automatic drain();
        for (int i = 0; i < 40 && sb.size() != 0; i++) @(negedge clk);
        check("drain", 32'(sb.size()), 32'd0);
        @(negedge clk);
    endtask

    // Monitor: compare results at every done pulse.
    always @(negedge clk) begin
        if (rst_n && done) begin
            if (sb.size() == 0) begin
                check("unexpected_done", 32'(done), 32'd0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("quotient", 32'(quotient), 32'(e.q));
                check("remainder", 32'(remainder), 32'(e.r));
                check("div_by_zero", 32'(div_by_zero), 32'(e.dz));
                check("done_cycle", 32'(cyc), 32'(e.due));
                check("busy_at_done", 32'(busy), 32'd0);
            end
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0;
        start = 1'b0;
        a     = '0;
        b     = '0;
        repeat (2) @(negedge clk);
        check("rst_quotient", 32'(quotient), 32'd0);
        check("rst_remainder", 32'(remainder), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_dbz", 32'(div_by_zero), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // Directed cases
        start_div(16'd100, 16'd7);        drain();
        start_div(16'hFFFF, 16'h8001);    drain();
        start_div(16'd5, 16'd0);          drain();
        check("dbz_hold_idle", 32'(div_by_zero), 32'd1);
        start_div(16'd9, 16'd3);          drain();
        start_div(16'd3, 16'hFFFF);       drain();
        start_div(16'hFFFF, 16'd1);       drain();
        start_div(16'd0, 16'd9);          drain();

        // A start during RUN is dropped
        start_div(16'd1000, 16'd3);
        repeat (4) @(negedge clk);
        a     = 16'd8;
        b     = 16'd2;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("busy_ignored_start", 32'(busy), 32'd1);
        drain();
        repeat (20) @(negedge clk);

        // Reset mid-RUN aborts with no done pulse
        start_div(16'd1000, 16'd3);
        repeat (7) @(negedge clk);
        check("hold_quotient", 32'(quotient), 32'd333);
        check("hold_remainder", 32'(remainder), 32'd1);
        rst_n = 1'b0;
        #1;
        check("abort_quotient", 32'(quotient), 32'd0);
        check("abort_remainder", 32'(remainder), 32'd0);
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_done", 32'(done), 32'd0);
        sb.delete();
        @(negedge clk);
        rst_n = 1'b1;
        repeat (20) @(negedge clk);
        start_div(16'd50, 16'd5);         drain();

        // Random cases, with occasional zero or tiny divisors
        for (int i = 0; i < 12; i++) begin
            logic [15:0] ra;
            logic [15:0] rb;
            ra = 16'($urandom);
            rb = ($urandom_range(0, 3) == 0) ? 16'($urandom_range(0, 2)) : 16'($urandom);
            start_div(ra, rb);
            drain();
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
